video_composite_mixer: RTL and testbench

- Parametrised successor of the composite square-wave video output stage.
- Takes timing strobes from the video timing generator and N overlay layers, each carrying hit, luma, hue and saturation. Produces the DAC code: sync, pedestal, colour burst, priority-mixed luma plus chroma, with saturation/clip.
- Adds a frame-synchronous mode register (normal / mono / colour bars / black), a sine chroma table generalised to 2^C_CPH_W phases, and a per-frame clip counter.

---
 rtl/video_composite_mixer.sv | 201 ++++++++++++++++++++
 tb/tb_video_composite_mixer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_composite_mixer.sv
// Composite video output stage: priority-mixes N overlay layers, adds sine-table chroma,
// inserts sync/pedestal/burst and clips to the DAC range through a 3-stage enabled pipeline.
module video_composite_mixer #(
  parameter int C_DAC_W     = 5,
  parameter int C_CPH_W     = 3,
  parameter int C_LAYERS    = 2,
  parameter int C_LUMA_W    = 5,
  parameter int C_SAT_W     = 4,
  parameter int C_PEDE      = 12,
  parameter int C_BURST_SAT = 3,
  parameter int C_ACTIVE_W  = 640
) (
  input  logic                          CK_i,
  input  logic                          RST_i,
  input  logic                          CK_EE_i,
  input  logic                          XSYNC_i,
  input  logic                          XBLK_i,
  input  logic                          CBURST_NOW_i,
  input  logic [C_CPH_W-1:0]            CPHs_i,
  input  logic [9:0]                    HCTRs_i,
  input  logic                          FRAME_TOP_i,
  input  logic [1:0]                    MODE_i,
  input  logic [C_LAYERS-1:0]           LAYER_HITs_i,
  input  logic [C_LAYERS*C_LUMA_W-1:0]  LAYER_LUMAs_i,
  input  logic [C_LAYERS*C_CPH_W-1:0]   LAYER_HUEs_i,
  input  logic [C_LAYERS*C_SAT_W-1:0]   LAYER_SATs_i,
  output logic [C_DAC_W-1:0]            VIDEOs_o,
  output logic                          XBLK_o,
  output logic                          CLIP_o,
  output logic [1:0]                    MODE_o,
  output logic [15:0]                   CLIP_CNTs_o
);

  localparam int NPH   = 1 << C_CPH_W;
  localparam int L_W   = (C_LUMA_W > 5) ? C_LUMA_W : 5;
  localparam int A_W   = (C_SAT_W > 3) ? C_SAT_W : 3;
  localparam int V_MAX = (1 << C_DAC_W) - 1;

  // round(4*sin) sampled at mid-phase; evaluated only at elaboration
  function automatic logic signed [3:0] sin_entry(input int p);
    real x;
    x = 4.0 * $sin(2.0 * 3.14159265358979 * (real'(p) + 0.5) / real'(NPH));
    if (x >= 0.0) return 4'($rtoi(x + 0.5));
    else          return 4'(-$rtoi(-x + 0.5));
  endfunction

  logic signed [3:0] sin_tab [NPH];
  for (genvar g = 0; g < NPH; g++) begin : g_sin
    localparam logic signed [3:0] S_G = sin_entry(g);
    assign sin_tab[g] = S_G;
  end

  // Stage 1 registers
  logic               xsync1_q, xblk1_q, cburst1_q;
  logic [1:0]         mode1_q;
  logic [L_W-1:0]     l1_q;
  logic [A_W-1:0]     a1_q;
  logic [C_CPH_W-1:0] p1_q, pb1_q;
  // Stage 2 registers
  logic               xsync2_q, xblk2_q, cburst2_q;
  logic [1:0]         mode2_q;
  logic [L_W-1:0]     l2_q;
  logic signed [15:0] c2_q, cb2_q;
  // Output / control registers
  logic [C_DAC_W-1:0] video_q;
  logic               xblk_q, clip_q;
  logic [1:0]         mode_q;
  logic [15:0]        clip_cnt_q, cnt_q;

  // S1: layer priority select or colour-bar generation
  logic [L_W-1:0]     l_d;
  logic [A_W-1:0]     a_d;
  logic [C_CPH_W-1:0] h_d, p_d, pb_d;
  logic [2:0]         bar;
  logic               found;
  int                 bar_i;

  always_comb begin
    l_d   = '0;
    a_d   = '0;
    h_d   = '0;
    found = 1'b0;
    for (int k = 0; k < C_LAYERS; k++) begin
      if (LAYER_HITs_i[k] && !found) begin
        found = 1'b1;
        l_d   = L_W'(LAYER_LUMAs_i[k*C_LUMA_W +: C_LUMA_W]);
        h_d   = LAYER_HUEs_i[k*C_CPH_W +: C_CPH_W];
        a_d   = A_W'(LAYER_SATs_i[k*C_SAT_W +: C_SAT_W]);
      end
    end
    bar_i = int'(HCTRs_i) * 8 / C_ACTIVE_W;
    bar   = (bar_i > 7) ? 3'd7 : bar_i[2:0];
    if (mode_q == 2'd2) begin
      l_d = L_W'((7 - int'(bar)) * 3);
      h_d = C_CPH_W'(bar);
      a_d = (bar != 3'd0 && bar != 3'd7) ? A_W'(6) : '0;
    end
    p_d  = CPHs_i + h_d;
    pb_d = CPHs_i + C_CPH_W'(NPH / 2);
  end

  // S2: chroma and burst amplitude, zeroed in mono
  logic signed [15:0] c_d, cb_d;

  always_comb begin
    c_d  = 16'((int'($signed({1'b0, a1_q})) * int'(sin_tab[p1_q])) >>> 2);
    cb_d = 16'((C_BURST_SAT * int'(sin_tab[pb1_q])) >>> 2);
    if (mode1_q == 2'd1) begin
      c_d  = '0;
      cb_d = '0;
    end
  end

  // S3: sync/burst/blank priority, then clipped picture level
  logic signed [31:0] v_d;
  logic [C_DAC_W-1:0] video_d;
  logic               clip_d;
  logic [15:0]        cnt_inc;

  always_comb begin
    v_d     = C_PEDE + int'(l2_q) + int'(c2_q);
    video_d = C_DAC_W'(C_PEDE);
    clip_d  = 1'b0;
    if (!xsync2_q) begin
      video_d = '0;
    end else if (cburst2_q) begin
      video_d = C_DAC_W'(C_PEDE + int'(cb2_q));
    end else if (!xblk2_q || mode2_q == 2'd3) begin
      video_d = C_DAC_W'(C_PEDE);
    end else if (v_d < 0) begin
      video_d = '0;
      clip_d  = 1'b1;
    end else if (v_d > V_MAX) begin
      video_d = C_DAC_W'(V_MAX);
      clip_d  = 1'b1;
    end else begin
      video_d = C_DAC_W'(v_d);
    end
    cnt_inc = (clip_d && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      xsync1_q   <= 1'b1;
      xblk1_q    <= 1'b0;
      cburst1_q  <= 1'b0;
      mode1_q    <= '0;
      l1_q       <= '0;
      a1_q       <= '0;
      p1_q       <= '0;
      pb1_q      <= '0;
      xsync2_q   <= 1'b1;
      xblk2_q    <= 1'b0;
      cburst2_q  <= 1'b0;
      mode2_q    <= '0;
      l2_q       <= '0;
      c2_q       <= '0;
      cb2_q      <= '0;
      video_q    <= C_DAC_W'(C_PEDE);
      xblk_q     <= 1'b0;
      clip_q     <= 1'b0;
      mode_q     <= '0;
      clip_cnt_q <= '0;
      cnt_q      <= '0;
    end else if (CK_EE_i) begin
      xsync1_q  <= XSYNC_i;
      xblk1_q   <= XBLK_i;
      cburst1_q <= CBURST_NOW_i;
      mode1_q   <= mode_q;
      l1_q      <= l_d;
      a1_q      <= a_d;
      p1_q      <= p_d;
      pb1_q     <= pb_d;
      xsync2_q  <= xsync1_q;
      xblk2_q   <= xblk1_q;
      cburst2_q <= cburst1_q;
      mode2_q   <= mode1_q;
      l2_q      <= l1_q;
      c2_q      <= c_d;
      cb2_q     <= cb_d;
      video_q   <= video_d;
      xblk_q    <= xblk2_q;
      clip_q    <= clip_d;
      // Frame boundary: publish count including this cycle's clip, restart counting
      if (FRAME_TOP_i) begin
        mode_q     <= MODE_i;
        clip_cnt_q <= cnt_inc;
        cnt_q      <= '0;
      end else begin
        cnt_q      <= cnt_inc;
      end
    end
  end

  assign VIDEOs_o    = video_q;
  assign XBLK_o      = xblk_q;
  assign CLIP_o      = clip_q;
  assign MODE_o      = mode_q;
  assign CLIP_CNTs_o = clip_cnt_q;

endmodule

// File: tb/tb_video_composite_mixer.sv
// Bench for video_composite_mixer: directed scenarios plus randomized traffic,
// scored against a per-sample behavioural model with a latency queue.
module tb_video_composite_mixer;

  localparam int C_DAC_W = 5;
  localparam int C_PEDE  = 12;
  localparam int W       = C_DAC_W + 2;
  localparam logic [W-1:0] IDLE = {1'b0, 1'b0, 5'd12};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, ee = 1'b1, xsync = 1'b1, xblk = 1'b0, cburst = 1'b0;
  logic [2:0]  cph = '0;
  logic [9:0]  hctr = '0;
  logic        frame_top = 1'b0;
  logic [1:0]  mode_in = '0;
  logic [1:0]  hits = '0;
  logic [9:0]  lumas = '0;
  logic [5:0]  hues = '0;
  logic [7:0]  sats = '0;

  logic [4:0]  video_o;
  logic        xblk_o, clip_o;
  logic [1:0]  mode_o;
  logic [15:0] clip_cnt_o;

  video_composite_mixer dut (
    .CK_i(clk), .RST_i(rst), .CK_EE_i(ee), .XSYNC_i(xsync), .XBLK_i(xblk),
    .CBURST_NOW_i(cburst), .CPHs_i(cph), .HCTRs_i(hctr), .FRAME_TOP_i(frame_top),
    .MODE_i(mode_in), .LAYER_HITs_i(hits), .LAYER_LUMAs_i(lumas),
    .LAYER_HUEs_i(hues), .LAYER_SATs_i(sats), .VIDEOs_o(video_o), .XBLK_o(xblk_o),
    .CLIP_o(clip_o), .MODE_o(mode_o), .CLIP_CNTs_o(clip_cnt_o)
  );

  // scoreboard
  int n_checks = 0, n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_exp;
  int m_mode = 0, m_cnt = 0, m_cnt_out = 0;
  int sin_tab [8] = '{2, 4, 4, 2, -2, -4, -4, -2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected {clip, xblk, video} for the sample currently on the inputs
  function automatic logic [W-1:0] ref_sample(input int mode);
    int l = 0, h = 0, a = 0, b, p, pb, c, cb, v, vid;
    logic clip = 1'b0;
    for (int k = 1; k >= 0; k--) begin
      if (hits[k]) begin
        l = int'(lumas[k*5 +: 5]);
        h = int'(hues[k*3 +: 3]);
        a = int'(sats[k*4 +: 4]);
      end
    end
    if (mode == 2) begin
      b = int'(hctr) * 8 / 640;
      if (b > 7) b = 7;
      l = (7 - b) * 3;
      h = b;
      a = (b >= 1 && b <= 6) ? 6 : 0;
    end
    p  = (int'(cph) + h) % 8;
    pb = (int'(cph) + 4) % 8;
    c  = (a * sin_tab[p]) >>> 2;
    cb = (3 * sin_tab[pb]) >>> 2;
    if (mode == 1) begin
      c  = 0;
      cb = 0;
    end
    if (!xsync)                  vid = 0;
    else if (cburst)             vid = C_PEDE + cb;
    else if (!xblk || mode == 3) vid = C_PEDE;
    else begin
      v = C_PEDE + l + c;
      if (v < 0)       begin vid = 0;  clip = 1'b1; end
      else if (v > 31) begin vid = 31; clip = 1'b1; end
      else             vid = v;
    end
    return {clip, xblk, 5'(vid)};
  endfunction

  task automatic model_edge();
    int clip;
    if (rst) begin
      exp_q = '{IDLE, IDLE};
      cur_exp = IDLE;
      m_mode = 0; m_cnt = 0; m_cnt_out = 0;
    end else if (ee) begin
      exp_q.push_back(ref_sample(m_mode));
      cur_exp = exp_q.pop_front();
      clip = int'(cur_exp[W-1]);
      if (frame_top) begin
        m_cnt_out = (m_cnt + clip > 65535) ? 65535 : m_cnt + clip;
        m_cnt = 0;
        m_mode = int'(mode_in);
      end else begin
        m_cnt = (m_cnt + clip > 65535) ? 65535 : m_cnt + clip;
      end
    end
  endtask

  // driver: one clock, model update at the edge, compare at the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("video", 32'(video_o), 32'(cur_exp[4:0]));
    check("xblk", 32'(xblk_o), 32'(cur_exp[5]));
    check("clip", 32'(clip_o), 32'(cur_exp[6]));
    check("mode", 32'(mode_o), 32'(m_mode));
    check("clip_cnt", 32'(clip_cnt_o), 32'(m_cnt_out));
  endtask

  task automatic set_layer(input int k, input logic hit, input int l, input int h, input int a);
    hits[k] = hit;
    lumas[k*5 +: 5] = 5'(l);
    hues[k*3 +: 3]  = 3'(h);
    sats[k*4 +: 4]  = 4'(a);
  endtask

  task automatic pulse_frame(input logic [1:0] m);
    mode_in = m;
    frame_top = 1'b1;
    step();
    frame_top = 1'b0;
  endtask

  int sweep_exp [8] = '{25, 28, 28, 25, 19, 16, 16, 19};
  int burst_exp [8] = '{10, 9, 9, 10, 13, 15, 15, 13};

  initial begin
    step(); step();
    check("rst_video", 32'(video_o), 32'd12);
    check("rst_mode", 32'(mode_o), 32'd0);
    rst = 1'b0;

    // sync tip reaches the output after the pipeline latency
    xsync = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("sync_lat", 32'(video_o), (i >= 2) ? 32'd0 : 32'd12);
    end
    xsync = 1'b1; xblk = 1'b1;

    // picture chroma sweep
    set_layer(0, 1'b1, 10, 0, 6);
    for (int i = 0; i < 10; i++) begin
      cph = (i < 8) ? 3'(i) : 3'd7;
      step();
      if (i >= 2) check("sweep", 32'(video_o), 32'(sweep_exp[i-2]));
    end

    // layer priority, then clipping and frame clip count
    cph = 3'd0;
    set_layer(0, 1'b1, 5, 0, 0);
    set_layer(1, 1'b1, 15, 2, 9);
    step(); step(); step();
    check("priority", 32'(video_o), 32'd17);
    set_layer(0, 1'b1, 30, 0, 0);
    for (int i = 0; i < 100; i++) step();
    check("clip_flag", 32'(clip_o), 32'd1);
    check("clip_level", 32'(video_o), 32'd31);
    set_layer(0, 1'b1, 5, 0, 0);
    step(); step(); step();
    pulse_frame(2'd0);
    check("clip_cnt_100", 32'(clip_cnt_o), 32'd100);

    // burst sweep in normal mode
    cburst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cph = (i < 8) ? 3'(i) : 3'd7;
      step();
      if (i >= 2) check("burst", 32'(video_o), 32'(burst_exp[i-2]));
    end
    cburst = 1'b0;

    // mid-frame mode request is ignored until frame top
    mode_in = 2'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mode_hold", 32'(mode_o), 32'd0);
    end
    pulse_frame(2'd2);
    check("mode_bars", 32'(mode_o), 32'd2);
    cph = 3'd0; hctr = 10'd0;
    step(); step(); step();
    check("bar0", 32'(video_o), 32'd31);
    check("bar0_clip", 32'(clip_o), 32'd1);
    hctr = 10'd560;
    step(); step(); step();
    check("bar7", 32'(video_o), 32'd12);

    // mono: burst flattens to pedestal
    pulse_frame(2'd1);
    cburst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cph = (i < 8) ? 3'(i) : 3'd7;
      step();
      if (i >= 4) check("mono_burst", 32'(video_o), 32'd12);
    end
    cburst = 1'b0;

    // sparse clock enable during the picture sweep, then reset mid-sweep
    pulse_frame(2'd0);
    set_layer(0, 1'b1, 10, 0, 6);
    for (int s = 0; s < 10; s++) begin
      cph = (s < 8) ? 3'(s) : 3'd7;
      for (int j = 0; j < 8; j++) begin
        ee = (j == 0);
        step();
        if (s >= 2) check("ee_sweep", 32'(video_o), 32'(sweep_exp[s-2]));
      end
      if (s == 6) begin
        rst = 1'b1; ee = 1'b0;
        step();
        check("rst_mid", 32'(video_o), 32'd12);
        rst = 1'b0;
        break;
      end
    end
    ee = 1'b1;

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      ee        = ($urandom_range(0, 3) != 0);
      xsync     = ($urandom_range(0, 15) != 0);
      xblk      = ($urandom_range(0, 7) != 0);
      cburst    = ($urandom_range(0, 9) == 0);
      cph       = 3'($urandom_range(0, 7));
      hctr      = 10'($urandom_range(0, 1023));
      frame_top = ($urandom_range(0, 40) == 0);
      mode_in   = 2'($urandom_range(0, 3));
      hits      = 2'($urandom_range(0, 3));
      lumas     = 10'($urandom_range(0, 1023));
      hues      = 6'($urandom_range(0, 63));
      sats      = 8'($urandom_range(0, 255));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
